// File: rtl/reg_writeback_unit.sv
// Register-file writeback initiator: merges ALU and load results
// through a registered write stage and tracks in-flight loads.
package params_pkg;
  localparam int WORD_SIZE = 32;
  typedef logic [WORD_SIZE-1:0] word;
  typedef enum logic [1:0] {
    NO_REG_OP      = 2'd0,
    WRITE_REG_DATA = 2'd1
  } reg_file_op_t;
endpackage

module reg_writeback_unit
  import params_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  word          alu_data,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [4:0]   ld_rd,
  input  word          ld_data,
  input  logic         issue_valid,
  input  logic [4:0]   issue_rd,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic         rs1_busy,
  output logic         rs2_busy,
  output reg_file_op_t mem_op,
  output logic [4:0]   rd,
  output word          write_data
);

  localparam int PW = $clog2(LD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(LD_FIFO_DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [4:0]    q_rd   [LD_FIFO_DEPTH];
  word           q_data [LD_FIFO_DEPTH];
  logic [31:0]   pending;
  logic [31:0]   pend_nxt;
  logic          alu_req;
  logic          push;
  logic          pop;

  assign ld_ready = !reset && (count < FULL);
  assign alu_req  = alu_valid && (alu_rd != 5'd0);
  assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign pop      = !alu_req && (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      q_rd[tail]   <= ld_rd;
      q_data[tail] <= ld_data;
    end
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A new issue overrides a same-cycle retire of that register.
  always_comb begin
    pend_nxt = pending;
    if (pop) pend_nxt[q_rd[head]] = 1'b0;
    if (issue_valid) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= pend_nxt;
  end

  assign rs1_busy = (rs1 != 5'd0) && pending[rs1];
  assign rs2_busy = (rs2 != 5'd0) && pending[rs2];

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_op     <= NO_REG_OP;
      rd         <= '0;
      write_data <= '0;
    end else if (alu_req) begin
      mem_op     <= WRITE_REG_DATA;
      rd         <= alu_rd;
      write_data <= alu_data;
    end else if (pop) begin
      mem_op     <= WRITE_REG_DATA;
      rd         <= q_rd[head];
      write_data <= q_data[head];
    end else begin
      mem_op     <= NO_REG_OP;
    end
  end

endmodule
